// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall/flush controller.
//   state_e : controller states (RUN, MEM_WAIT)
//   FWD_*   : EX operand forwarding select encodings
//   NOP_INSN: instruction word inserted by the datapath on a flush (addi x0,x0,0)
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    localparam logic [1:0]  FWD_RF   = 2'b00;
    localparam logic [1:0]  FWD_MEM  = 2'b01;
    localparam logic [1:0]  FWD_WB   = 2'b10;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/pipe_fwd_unit.sv
// Combinational forwarding comparator for one EX source operand.
//   ex_rs                 : EX source register index
//   mem_rd / mem_regwrite : EX/MEM destination and write enable
//   wb_rd  / wb_regwrite  : MEM/WB destination and write enable
//   fwd                   : selected operand source (MEM beats WB, x0 never forwarded)
module pipe_fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] ex_rs,
    input  logic [4:0] mem_rd,
    input  logic       mem_regwrite,
    input  logic [4:0] wb_rd,
    input  logic       wb_regwrite,
    output logic [1:0] fwd
);

    always_comb begin
        fwd = FWD_RF;
        if (mem_regwrite && (mem_rd != 5'd0) && (mem_rd == ex_rs)) begin
            fwd = FWD_MEM;
        end else if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == ex_rs)) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, stall and flush sequencer for the 5-stage pipeline.
// Inputs : ID/EX source indices and use bits, EX/MEM/WB destinations and write
//          enables, ex_memread, ex_redirect, mem_req, dmem_ready; clk, rst (sync, high).
// Outputs: pc_en/ifid_en/idex_en/exmem_en stage enables, ifid_flush/idex_flush,
//          memwb_bubble, fwd_a/fwd_b forwarding selects, sticky mem_fault, and
//          three 32-bit perf counters.
// Control outputs are combinational from inputs and registered state.
// Optional build macro PIPE_HAZARD_CTRL_PERF_EN enables the perf counters;
// otherwise the perf outputs are tied to zero.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  ex_rs1,
    input  logic [4:0]  ex_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_regwrite,
    input  logic        ex_memread,
    input  logic        ex_redirect,
    input  logic [4:0]  mem_rd,
    input  logic        mem_regwrite,
    input  logic        mem_req,
    input  logic        dmem_ready,
    input  logic [4:0]  wb_rd,
    input  logic        wb_regwrite,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        memwb_bubble,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        mem_fault,
    output logic [31:0] perf_lu_stall,
    output logic [31:0] perf_mem_stall,
    output logic [31:0] perf_flush
);

    localparam int unsigned WCNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MEM_TIMEOUT);

    state_e            state;
    state_e            state_nxt;
    logic [WCNT_W-1:0] wcnt;
    logic [WCNT_W-1:0] wcnt_nxt;
    logic              hold;
    logic              fault_set;
    logic              lu_hit;
    logic [1:0]        fwd_a_raw;
    logic [1:0]        fwd_b_raw;

    pipe_fwd_unit u_fwd_a (
        .ex_rs        (ex_rs1),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .fwd          (fwd_a_raw)
    );

    pipe_fwd_unit u_fwd_b (
        .ex_rs        (ex_rs2),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .fwd          (fwd_b_raw)
    );

    // Load in EX whose destination is read by the instruction in ID.
    assign lu_hit = ex_memread && ex_regwrite && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

    // State register, wait counter and sticky fault.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            wcnt      <= '0;
            mem_fault <= 1'b0;
        end else begin
            state     <= state_nxt;
            wcnt      <= wcnt_nxt;
            mem_fault <= mem_fault | fault_set;
        end
    end

    // Next state and stage controls. A timeout is treated as a release cycle.
    always_comb begin
        state_nxt    = state;
        wcnt_nxt     = wcnt;
        hold         = 1'b0;
        fault_set    = 1'b0;
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        memwb_bubble = 1'b0;
        fwd_a        = FWD_RF;
        fwd_b        = FWD_RF;

        case (state)
            RUN: begin
                if (mem_req && !dmem_ready) begin
                    hold      = 1'b1;
                    state_nxt = MEM_WAIT;
                    wcnt_nxt  = WCNT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_nxt = RUN;
                    wcnt_nxt  = '0;
                end else if (wcnt == WCNT_MAX) begin
                    state_nxt = RUN;
                    wcnt_nxt  = '0;
                    fault_set = 1'b1;
                end else begin
                    hold     = 1'b1;
                    wcnt_nxt = wcnt + WCNT_W'(1);
                end
            end
        endcase

        if (!rst) begin
            fwd_a = fwd_a_raw;
            fwd_b = fwd_b_raw;
            if (hold) begin
                // Whole front of the pipe frozen; EX keeps any redirect for the release cycle.
                pc_en        = 1'b0;
                ifid_en      = 1'b0;
                idex_en      = 1'b0;
                exmem_en     = 1'b0;
                memwb_bubble = 1'b1;
            end else if (ex_redirect) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (lu_hit && (state == RUN)) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end
        end else begin
            fault_set = 1'b0;
        end
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    // Event counters derived from the issued controls; they wrap at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_lu_stall  <= '0;
            perf_mem_stall <= '0;
            perf_flush     <= '0;
        end else begin
            if (!pc_en && !memwb_bubble) perf_lu_stall  <= perf_lu_stall + 32'd1;
            if (memwb_bubble)            perf_mem_stall <= perf_mem_stall + 32'd1;
            if (ifid_flush)              perf_flush     <= perf_flush + 32'd1;
        end
    end
`else
    assign perf_lu_stall  = '0;
    assign perf_mem_stall = '0;
    assign perf_flush     = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (MEM_TIMEOUT = 15).
module tb_pipe_hazard_ctrl;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    localparam int unsigned PERF = 1;
`else
    localparam int unsigned PERF = 0;
`endif

    localparam logic [6:0] C_RUN  = 7'b1111000;
    localparam logic [6:0] C_LU   = 7'b0011010;
    localparam logic [6:0] C_RDR  = 7'b1111110;
    localparam logic [6:0] C_HOLD = 7'b0000001;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic        id_use_rs1, id_use_rs2, ex_regwrite, ex_memread, ex_redirect;
    logic        mem_regwrite, mem_req, dmem_ready, wb_regwrite;
    logic        pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_bubble;
    logic [1:0]  fwd_a, fwd_b;
    logic        mem_fault;
    logic [31:0] perf_lu_stall, perf_mem_stall, perf_flush;
    logic [6:0]  ctl;

    int tests = 0;
    int fails = 0;

    assign ctl = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_bubble};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_redirect(ex_redirect),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_req(mem_req), .dmem_ready(dmem_ready),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_bubble(memwb_bubble),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_fault(mem_fault),
        .perf_lu_stall(perf_lu_stall), .perf_mem_stall(perf_mem_stall), .perf_flush(perf_flush)
    );

    task automatic clear_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rs1 = 5'd0; ex_rs2 = 5'd0; ex_rd = 5'd0;
        ex_regwrite = 1'b0; ex_memread = 1'b0; ex_redirect = 1'b0;
        mem_rd = 5'd0; mem_regwrite = 1'b0; mem_req = 1'b0; dmem_ready = 1'b0;
        wb_rd = 5'd0; wb_regwrite = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        mem_req = 1'b1; ex_redirect = 1'b1;
        mem_rd = 5'd3; mem_regwrite = 1'b1; ex_rs1 = 5'd3;
        #1;
        tests++;
        if (ctl !== C_RUN || fwd_a !== 2'b00) begin
            fails++; $display("FAIL reset_forced ctl=%b fwd_a=%b exp ctl=%b fwd_a=00", ctl, fwd_a, C_RUN);
        end
        tick(); tick();
        rst = 1'b0;
        clear_inputs();
        #1;
        tests++;
        if (ctl !== C_RUN || mem_fault !== 1'b0 || perf_lu_stall !== 32'd0 ||
            perf_mem_stall !== 32'd0 || perf_flush !== 32'd0) begin
            fails++; $display("FAIL reset_state ctl=%b fault=%b perf=%0d/%0d/%0d exp ctl=%b fault=0 perf=0",
                              ctl, mem_fault, perf_lu_stall, perf_mem_stall, perf_flush, C_RUN);
        end
    endtask

    task automatic test_load_use();
        clear_inputs();
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        #1;
        tests++;
        if (ctl !== C_LU) begin fails++; $display("FAIL lu_rs1 ctl=%b exp=%b", ctl, C_LU); end
        tick();
        clear_inputs();
        #1;
        tests++;
        if (ctl !== C_RUN || perf_lu_stall !== 32'(PERF)) begin
            fails++; $display("FAIL lu_after ctl=%b lu=%0d exp ctl=%b lu=%0d", ctl, perf_lu_stall, C_RUN, PERF);
        end
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
        #1;
        tests++;
        if (ctl !== C_LU) begin fails++; $display("FAIL lu_rs2 ctl=%b exp=%b", ctl, C_LU); end
        tick();
        clear_inputs();
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
        #1;
        tests++;
        if (ctl !== C_RUN) begin fails++; $display("FAIL lu_x0 ctl=%b exp=%b", ctl, C_RUN); end
        ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b0;
        #1;
        tests++;
        if (ctl !== C_RUN) begin fails++; $display("FAIL lu_unused ctl=%b exp=%b", ctl, C_RUN); end
        id_use_rs1 = 1'b1; ex_memread = 1'b0;
        #1;
        tests++;
        if (ctl !== C_RUN) begin fails++; $display("FAIL lu_not_load ctl=%b exp=%b", ctl, C_RUN); end
        tick();
        clear_inputs();
    endtask

    task automatic test_forwarding();
        clear_inputs();
        mem_rd = 5'd7; mem_regwrite = 1'b1; wb_rd = 5'd7; wb_regwrite = 1'b1; ex_rs2 = 5'd7; ex_rs1 = 5'd9;
        #1;
        tests++;
        if (fwd_b !== 2'b01 || fwd_a !== 2'b00) begin
            fails++; $display("FAIL fwd_mem_prio fwd_b=%b fwd_a=%b exp 01/00", fwd_b, fwd_a);
        end
        mem_rd = 5'd0;
        #1;
        tests++;
        if (fwd_b !== 2'b10) begin fails++; $display("FAIL fwd_wb fwd_b=%b exp=10", fwd_b); end
        ex_rs1 = 5'd0;
        #1;
        tests++;
        if (fwd_a !== 2'b00) begin fails++; $display("FAIL fwd_x0_mem fwd_a=%b exp=00", fwd_a); end
        mem_rd = 5'd7; mem_regwrite = 1'b0; ex_rs1 = 5'd7;
        #1;
        tests++;
        if (fwd_a !== 2'b10 || fwd_b !== 2'b10) begin
            fails++; $display("FAIL fwd_mem_nowrite fwd_a=%b fwd_b=%b exp 10/10", fwd_a, fwd_b);
        end
        wb_rd = 5'd0; ex_rs1 = 5'd0; ex_rs2 = 5'd0;
        #1;
        tests++;
        if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
            fails++; $display("FAIL fwd_x0_wb fwd_a=%b fwd_b=%b exp 00/00", fwd_a, fwd_b);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_mem_wait();
        clear_inputs();
        mem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++;
            if (ctl !== C_HOLD) begin fails++; $display("FAIL mem_hold_%0d ctl=%b exp=%b", i, ctl, C_HOLD); end
            tick();
        end
        dmem_ready = 1'b1;
        #1;
        tests++;
        if (ctl !== C_RUN) begin fails++; $display("FAIL mem_release ctl=%b exp=%b", ctl, C_RUN); end
        tick();
        clear_inputs();
        #1;
        tests++;
        if (ctl !== C_RUN || perf_mem_stall !== 32'(3 * PERF)) begin
            fails++; $display("FAIL mem_back_run ctl=%b ms=%0d exp ctl=%b ms=%0d", ctl, perf_mem_stall, C_RUN, 3 * PERF);
        end
    endtask

    task automatic test_redirect_wait();
        clear_inputs();
        mem_req = 1'b1; ex_redirect = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            tests++;
            if (ctl !== C_HOLD) begin fails++; $display("FAIL rdr_hold_%0d ctl=%b exp=%b", i, ctl, C_HOLD); end
            tick();
        end
        dmem_ready = 1'b1;
        #1;
        tests++;
        if (ctl !== C_RDR) begin fails++; $display("FAIL rdr_release ctl=%b exp=%b", ctl, C_RDR); end
        tick();
        clear_inputs();
        #1;
        tests++;
        if (perf_flush !== 32'(PERF) || perf_mem_stall !== 32'(5 * PERF)) begin
            fails++; $display("FAIL rdr_perf fl=%0d ms=%0d exp fl=%0d ms=%0d", perf_flush, perf_mem_stall, PERF, 5 * PERF);
        end
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        mem_req = 1'b1;
        #1;
        tests++;
        if (ctl !== C_HOLD) begin fails++; $display("FAIL b2b_hold1 ctl=%b exp=%b", ctl, C_HOLD); end
        tick();
        dmem_ready = 1'b1;
        #1;
        tests++;
        if (ctl !== C_RUN) begin fails++; $display("FAIL b2b_rel1 ctl=%b exp=%b", ctl, C_RUN); end
        tick();
        dmem_ready = 1'b0;
        #1;
        tests++;
        if (ctl !== C_HOLD) begin fails++; $display("FAIL b2b_hold2 ctl=%b exp=%b", ctl, C_HOLD); end
        tick();
        dmem_ready = 1'b1;
        #1;
        tests++;
        if (ctl !== C_RUN) begin fails++; $display("FAIL b2b_rel2 ctl=%b exp=%b", ctl, C_RUN); end
        tick();
        #1;
        tests++;
        if (ctl !== C_RUN) begin fails++; $display("FAIL single_cycle ctl=%b exp=%b", ctl, C_RUN); end
        tick();
        // Load-use only fires in RUN, so this confirms the single-cycle access stayed there.
        clear_inputs();
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd8; id_rs2 = 5'd8; id_use_rs2 = 1'b1;
        #1;
        tests++;
        if (ctl !== C_LU) begin fails++; $display("FAIL single_cycle_run ctl=%b exp=%b", ctl, C_LU); end
        tick();
        clear_inputs();
    endtask

    task automatic test_timeout();
        clear_inputs();
        mem_req = 1'b1;
        for (int i = 0; i < 15; i++) begin
            #1;
            tests++;
            if (ctl !== C_HOLD) begin fails++; $display("FAIL to_hold_%0d ctl=%b exp=%b", i, ctl, C_HOLD); end
            tick();
        end
        #1;
        tests++;
        if (ctl !== C_RUN || mem_fault !== 1'b0) begin
            fails++; $display("FAIL to_release ctl=%b fault=%b exp ctl=%b fault=0", ctl, mem_fault, C_RUN);
        end
        tick();
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++;
            if (mem_fault !== 1'b1 || ctl !== C_RUN) begin
                fails++; $display("FAIL to_sticky_%0d fault=%b ctl=%b exp fault=1 ctl=%b", i, mem_fault, ctl, C_RUN);
            end
            tick();
        end
    endtask

    task automatic test_lu_redirect();
        clear_inputs();
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        ex_redirect = 1'b1;
        #1;
        tests++;
        if (ctl !== C_RDR) begin fails++; $display("FAIL lu_redirect ctl=%b exp=%b", ctl, C_RDR); end
        tick();
        clear_inputs();
        #1;
        tests++;
        if (perf_lu_stall !== 32'(3 * PERF) || perf_mem_stall !== 32'(22 * PERF) || perf_flush !== 32'(2 * PERF)) begin
            fails++; $display("FAIL perf_totals lu=%0d ms=%0d fl=%0d exp %0d/%0d/%0d",
                              perf_lu_stall, perf_mem_stall, perf_flush, 3 * PERF, 22 * PERF, 2 * PERF);
        end
    endtask

    task automatic test_rst_in_wait();
        clear_inputs();
        mem_req = 1'b1; ex_redirect = 1'b1;
        #1;
        tests++;
        if (ctl !== C_HOLD) begin fails++; $display("FAIL rstw_hold ctl=%b exp=%b", ctl, C_HOLD); end
        tick();
        rst = 1'b1;
        #1;
        tests++;
        if (ctl !== C_RUN) begin fails++; $display("FAIL rstw_forced ctl=%b exp=%b", ctl, C_RUN); end
        tick();
        rst = 1'b0;
        clear_inputs();
        #1;
        tests++;
        if (ctl !== C_RUN || mem_fault !== 1'b0 || perf_lu_stall !== 32'd0 ||
            perf_mem_stall !== 32'd0 || perf_flush !== 32'd0) begin
            fails++; $display("FAIL rstw_state ctl=%b fault=%b perf=%0d/%0d/%0d exp ctl=%b fault=0 perf=0",
                              ctl, mem_fault, perf_lu_stall, perf_mem_stall, perf_flush, C_RUN);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_forwarding();
        test_mem_wait();
        test_redirect_wait();
        test_back_to_back();
        test_timeout();
        test_lu_redirect();
        test_rst_in_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard, stall and flush sequencer for the 5-stage pipeline. Watches register indices and control bits in the ID, EX, MEM and WB stages plus the data-memory handshake. Drives the per-stage enable and flush controls for the IF/ID, ID/EX, EX/MEM and MEM/WB registers, and the EX-stage forwarding selects. Load-use stalls, taken-branch/jump redirects and multi-cycle data-memory waits are sequenced here, not in the datapath.

## Interface
- MEM_TIMEOUT, 15: maximum cycles spent in MEM_WAIT before a fault; legal range 1–255.
- clk  in  1  pipeline clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1 each  ID instruction reads that source.
- ex_rs1, ex_rs2  in  5 each  source registers of the instruction in EX.
- ex_rd  in  5  EX destination; ex_regwrite, ex_memread  in  1 each.
- ex_redirect  in  1  branch taken or jump resolved in EX.
- mem_rd  in  5  MEM destination; mem_regwrite  in  1.
- mem_req  in  1  MEM stage holds a load or store.
- dmem_ready  in  1  data memory completes the access this cycle.
- wb_rd  in  5  WB destination; wb_regwrite  in  1.
- pc_en, ifid_en, idex_en, exmem_en  out  1 each  stage advance enables.
- ifid_flush, idex_flush  out  1 each  insert NOP (0x00000013, controls zero).
- memwb_bubble  out  1  MEM/WB captures a bubble (RegWrite=0).
- fwd_a, fwd_b  out  2 each  EX operand source: 00 regfile, 01 EX/MEM ALU result, 10 MEM/WB write data.
- mem_fault  out  1  sticky; data memory timed out.
- perf_lu_stall, perf_mem_stall, perf_flush  out  32 each  performance counters.

## Operation
- States: RUN, MEM_WAIT. Wait counter wcnt is $clog2(MEM_TIMEOUT+1) bits wide.
- Load-use (RUN only): ex_memread & ex_regwrite & ex_rd≠0, and (id_use_rs1 & id_rs1==ex_rd or id_use_rs2 & id_rs2==ex_rd).
  - Response: pc_en=0, ifid_en=0, idex_flush=1 for exactly one cycle.
- Redirect (RUN, no memory hold): ifid_flush=1 and idex_flush=1; all enables 1.
  - Redirect beats load-use in the same cycle; load-use outputs are suppressed.
- Memory hold:
  - In RUN, mem_req & ~dmem_ready drops pc_en, ifid_en, idex_en and exmem_en, sets memwb_bubble=1, and moves to MEM_WAIT with wcnt=1.
  - In MEM_WAIT the hold continues and wcnt increments.
  - On the first cycle of dmem_ready=1: all enables 1, memwb_bubble=0, next state RUN, wcnt=0.
- Hold priority: memory hold masks load-use and redirect. EX is frozen, so ex_redirect stays asserted, and its flushes take effect on the release cycle.
- Timeout: in MEM_WAIT, wcnt==MEM_TIMEOUT with dmem_ready=0 treats that cycle as the release cycle and sets mem_fault=1. mem_fault is cleared only by rst.
- Forwarding, per operand:
  - 01 if mem_regwrite & mem_rd≠0 & mem_rd==ex_rsN.
  - Else 10 if wb_regwrite & wb_rd≠0 & wb_rd==ex_rsN.
  - Else 00. MEM has priority over WB.
- x0 is never a hazard source.

## Timing
- All control outputs are combinational from the current inputs and registered state. There is no added latency; they are valid in the same cycle.
- Registered elements: state, wcnt, mem_fault, perf counters.
- Reset values (during rst and on the cycle after):
  - state=RUN, wcnt=0, mem_fault=0, perf counters=0.
  - While rst=1, outputs are forced to: enables=1, flushes=0, memwb_bubble=0, fwd=00.
- rst asserted in MEM_WAIT returns to RUN on the next edge; any pending redirect is dropped.
- A back-to-back memory access (mem_req again right after release) re-enters MEM_WAIT if dmem_ready=0; there is no idle cycle required.
- A single-cycle access (dmem_ready=1 in the same cycle as mem_req) never leaves RUN.

## Configuration
- PIPE_HAZARD_CTRL_PERF_EN defined: three 32-bit wrapping counters.
  - perf_lu_stall: +1 per load-use stall cycle.
  - perf_mem_stall: +1 per memory-hold cycle.
  - perf_flush: +1 per cycle with ifid_flush=1.
- Undefined: counter logic is not built and the perf outputs are tied to 0. Ports are unchanged.

## Structure
- Package pipe_ctrl_pkg: state enum (RUN, MEM_WAIT), fwd select constants (FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10), NOP encoding 32'h00000013.
- Sub-module pipe_fwd_unit: purely combinational forwarding comparator, instantiated once per operand.

## Test plan
- Load-use: ex lw x5 (ex_memread=1, ex_rd=5), id_rs1=5, id_use_rs1=1 -> one cycle with pc_en=0, ifid_en=0, idex_flush=1; perf_lu_stall=1.
- Forwarding: mem_rd=7 and wb_rd=7 with both regwrite=1, ex_rs2=7 -> fwd_b=01. Repeat with mem_rd=0 -> fwd_b=10. Then ex_rs1=0 -> fwd_a=00.
- Memory wait: mem_req=1 with dmem_ready low for 3 cycles -> 3 hold cycles with memwb_bubble=1; 4th cycle releases; state returns to RUN.
- Redirect during wait: ex_redirect=1 throughout a 2-cycle wait -> no flushes while holding; ifid_flush=idex_flush=1 on the release cycle.
- Timeout: MEM_TIMEOUT=15, dmem_ready stuck low -> release after the cycle with wcnt==15; mem_fault=1 and stays 1 until rst.
- Simultaneous load-use + redirect in RUN -> flushes=1, pc_en=1. Then rst during MEM_WAIT -> state=RUN, mem_fault=0, perf counters=0.
